// File: rtl/tmds_ddr_receiver.sv
// TMDS receive channel: DDR bit-pair deserialiser, control-token word alignment and TMDS decode.
// Optional lock statistics (slip_count, loss_count) are enabled by defining TMDS_LOCKSTAT_EN.
module tmds_ddr_receiver #(
  parameter int LOCK_COUNT = 8,
  parameter int MAX_GAP    = 4095,
  parameter bit INVERT     = 1'b0
) (
  input  logic       clk_shift,
  input  logic       rst_n,
  input  logic [1:0] in_tmds,
  output logic       out_valid,
  output logic       out_de,
  output logic [7:0] out_data,
  output logic [1:0] out_ctrl,
  output logic       locked,
  output logic [3:0] bit_offset
`ifdef TMDS_LOCKSTAT_EN
  ,
  output logic [7:0] slip_count,
  output logic [7:0] loss_count
`endif
);

  localparam int RW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int GW = $clog2(MAX_GAP + 2);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q;
  logic [19:2]   shift_q;
  logic [19:0]   shift_next;
  logic [9:0]    sym;
  logic [9:0]    sym_q;
  logic          strobe;
  logic          valid_pend;
  logic [RW-1:0] run_q, run_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    off_d;
  logic          locked_d;
  logic          slip, loss;
  logic          is_tok, is_tok_q;
  logic [1:0]    tok_val, tok_val_q;
  logic [7:0]    dec_d;
  logic [7:0]    dec;

  // The 20-bit window is the 18 stored bits plus the pair arriving this cycle.
  assign shift_next = {in_tmds[1] ^ INVERT, in_tmds[0] ^ INVERT, shift_q};
  assign sym        = 10'(shift_next >> (4'd10 - bit_offset));
  assign strobe     = (phase_q == 3'd4);

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    unique case (sym)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    gap_d    = gap_q;
    off_d    = bit_offset;
    locked_d = locked;
    slip     = 1'b0;
    loss     = 1'b0;
    if (strobe) begin
      unique case (state_q)
        HUNT: begin
          if (is_tok) begin
            if (LOCK_COUNT <= 1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              gap_d    = '0;
            end else begin
              state_d = VERIFY;
              run_d   = RW'(1);
            end
          end else begin
            slip = 1'b1;
          end
        end
        VERIFY: begin
          if (!is_tok) begin
            state_d = HUNT;
            run_d   = '0;
            slip    = 1'b1;
          end else if (run_q == RW'(LOCK_COUNT - 1)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            gap_d    = '0;
            run_d    = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        LOCKED: begin
          if (is_tok) begin
            gap_d = '0;
          end else if (gap_q == GW'(MAX_GAP)) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            gap_d    = '0;
            run_d    = '0;
            loss     = 1'b1;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
      if (slip) off_d = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
    end
  end

  always_comb begin
    dec_d = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec   = '0;
    dec[0] = dec_d[0];
    for (int unsigned i = 1; i < 8; i++)
      dec[i] = sym_q[8] ? (dec_d[i] ^ dec_d[i-1]) : ~(dec_d[i] ^ dec_d[i-1]);
  end

  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      phase_q    <= '0;
      shift_q    <= '0;
      run_q      <= '0;
      gap_q      <= '0;
      bit_offset <= '0;
      locked     <= 1'b0;
      sym_q      <= '0;
      is_tok_q   <= 1'b0;
      tok_val_q  <= '0;
      valid_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_de     <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
    end else begin
      phase_q    <= strobe ? 3'd0 : phase_q + 3'd1;
      shift_q    <= shift_next[19:2];
      state_q    <= state_d;
      run_q      <= run_d;
      gap_q      <= gap_d;
      bit_offset <= off_d;
      locked     <= locked_d;
      valid_pend <= strobe & locked_d;
      out_valid  <= valid_pend;
      if (strobe) begin
        sym_q     <= sym;
        is_tok_q  <= is_tok;
        tok_val_q <= tok_val;
      end
      if (valid_pend) begin
        out_de <= ~is_tok_q;
        if (is_tok_q) begin
          out_ctrl <= tok_val_q;
          out_data <= '0;
        end else begin
          out_data <= dec;
        end
      end
    end
  end

`ifdef TMDS_LOCKSTAT_EN
  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      slip_count <= '0;
      loss_count <= '0;
    end else begin
      if (slip && slip_count != '1) slip_count <= slip_count + 8'd1;
      if (loss && loss_count != '1) loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule
